// File: rtl/mult64_pkg.sv
// Shared widths and types for the 64x64 unsigned multiplier.
package mult64_pkg;

  localparam int unsigned OP_W   = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned PROD_W = 128;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [HALF_W-1:0] half_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage : mult64_pkg

// File: rtl/mult32x32.sv
// Combinational unsigned 32x32 -> 64 partial-product multiplier.
module mult32x32
  import mult64_pkg::*;
(
  input  half_t                 x,
  input  half_t                 y,
  output logic [2*HALF_W-1:0]   p_c
);

  assign p_c = (2*HALF_W)'(x) * (2*HALF_W)'(y);

endmodule : mult32x32

// File: rtl/mult_64.sv
// Unsigned 64x64 -> 128 multiplier, one registered output stage.
// Defining MULT64_INPUT_REG_EN adds an operand register (2-edge latency).
module mult_64
  import mult64_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  output logic [PROD_W-1:0]  c
);

  localparam int unsigned PP_W  = 2 * HALF_W;
  localparam int unsigned MID_W = PP_W + 1;

  operand_t          op_a;
  operand_t          op_b;
  logic [PP_W-1:0]   pp_ll;
  logic [PP_W-1:0]   pp_lh;
  logic [PP_W-1:0]   pp_hl;
  logic [PP_W-1:0]   pp_hh;
  logic [MID_W-1:0]  mid_sum;
  product_t          c_d;
  product_t          c_q;

`ifdef MULT64_INPUT_REG_EN
  operand_t a_d;
  operand_t b_d;
  operand_t a_q;
  operand_t b_q;

  always_comb begin
    a_d = a;
    b_d = b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  mult32x32 u_pp_ll (.x(op_a[HALF_W-1:0]),    .y(op_b[HALF_W-1:0]),    .p_c(pp_ll));
  mult32x32 u_pp_lh (.x(op_a[HALF_W-1:0]),    .y(op_b[OP_W-1:HALF_W]), .p_c(pp_lh));
  mult32x32 u_pp_hl (.x(op_a[OP_W-1:HALF_W]), .y(op_b[HALF_W-1:0]),    .p_c(pp_hl));
  mult32x32 u_pp_hh (.x(op_a[OP_W-1:HALF_W]), .y(op_b[OP_W-1:HALF_W]), .p_c(pp_hh));

  // Cross terms summed first with a carry bit so the middle column stays exact.
  always_comb begin
    mid_sum = MID_W'(pp_lh) + MID_W'(pp_hl);
    c_d     = PROD_W'(pp_ll)
            + (PROD_W'(mid_sum) << HALF_W)
            + (PROD_W'(pp_hh)   << OP_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

endmodule : mult_64

// File: tb/tb_mult_64.sv
// Directed and seeded-random checks for mult_64 in either latency build.
module tb_mult_64;

  import mult64_pkg::*;

`ifdef MULT64_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic     clk;
  logic     rst;
  operand_t a;
  operand_t b;
  product_t c;

  product_t exp_q [LAT];
  int       n_checks;
  int       n_fail;

  mult_64 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input product_t got, input product_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%032h expected 0x%032h", tag, got, exp);
    end
  endtask

  // Drive one operand pair for one edge; ex is the hand-computed product of av*bv.
  task automatic cycle(input operand_t av, input operand_t bv, input logic r,
                       input product_t ex, input string tag);
    a   = av;
    b   = bv;
    rst = r;
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) exp_q[i] = exp_q[i-1];
    exp_q[0] = r ? '0 : ex;
    if (r) begin
      for (int i = 0; i < LAT; i++) exp_q[i] = '0;
    end
    check_eq(tag, c, exp_q[LAT-1]);
  endtask

  initial begin
    operand_t ra;
    operand_t rb;
    product_t held;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < LAT; i++) exp_q[i] = '0;
    a   = '1;
    b   = '1;
    rst = 1'b1;

    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '0, "reset_0");
    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '0, "reset_1");
    cycle(64'd2, 64'd3, 1'b0, 128'h6, "release");

    cycle(64'd0,  64'd0,  1'b0, 128'h0,  "zero");
    cycle(64'd1,  64'd1,  1'b0, 128'h1,  "one");
    cycle(64'd5,  64'd7,  1'b0, 128'h23, "five_seven");
    cycle(64'd10, 64'd15, 1'b0, 128'h96, "ten_fifteen");

    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "max_max");
    cycle(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, "msb_msb");
    cycle(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0,
          128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000, "cross_term");

    cycle(64'd2, 64'd3, 1'b0, 128'h6,  "b2b_0");
    cycle(64'd5, 64'd7, 1'b0, 128'h23, "b2b_1");
    cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, "b2b_2");
    cycle(64'd10, 64'd15, 1'b0, 128'h96, "b2b_3");

    // A reset pulse between edges must not disturb the held product.
    held = c;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_between_edges", c, held);

    cycle(64'd10, 64'd15, 1'b0, 128'h96, "hold_stable");
    cycle(64'd5,  64'd7,  1'b0, 128'h23, "mid_pre");
    cycle(64'd1,  64'd1,  1'b1, '0,      "mid_reset");
    cycle(64'd2,  64'd3,  1'b0, 128'h6,  "mid_resume_0");
    cycle(64'd5,  64'd7,  1'b0, 128'h23, "mid_resume_1");
    cycle(64'd0,  64'd0,  1'b0, 128'h0,  "mid_resume_2");

    void'($urandom(32'h5EED_0064));
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 50 == 0) ra[63:32] = '1;
      cycle(ra, rb, 1'b0, PROD_W'(ra) * PROD_W'(rb), "random");
    end
    for (int i = 0; i < LAT; i++) cycle(64'd0, 64'd0, 1'b0, '0, "flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mult_64
